// File: rtl/hazard_pkg.sv
// Shared encodings and types for the RV32I pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned FWD_W      = 2;

  // E-stage operand mux encodings
  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  // Data-memory sequencing states
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Grouped pipeline-register controls
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
  } pipe_ctrl_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select for the E stage; M result beats W result.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_rs_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_m,
  input  logic              i_regwrite_w,
  output logic [FWD_W-1:0]  o_fwd
);

  logic hit_m;
  logic hit_w;

  // x0 is never a forwarding source
  assign hit_m = i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs_e);
  assign hit_w = i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs_e);

  // Priority select: youngest producer wins
  always_comb begin
    o_fwd = FWD_RF;
    if (hit_m) begin
      o_fwd = FWD_MEM;
    end else if (hit_w) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV32I pipeline: forwarding,
// load-use stall, branch flush and dmem wait/timeout sequencing.
// Optional perf counters are built when HAZ_PERF_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [REG_AW-1:0] i_rs1_d,
  input  logic [REG_AW-1:0] i_rs2_d,
  input  logic [REG_AW-1:0] i_rs1_e,
  input  logic [REG_AW-1:0] i_rs2_e,
  input  logic [REG_AW-1:0] i_rd_e,
  input  logic              i_load_e,
  input  logic              i_pcsrc_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_m,
  input  logic              i_regwrite_w,
  input  logic              i_memreq_m,
  input  logic              i_dmem_ready,
  input  logic              i_err_clr,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_stall_e,
  output logic              o_stall_m,
  output logic              o_flush_d,
  output logic              o_flush_e,
  output logic              o_flush_m,
  output logic [FWD_W-1:0]  o_fwd_a_e,
  output logic [FWD_W-1:0]  o_fwd_b_e,
  output logic              o_mem_err,
  output logic [PERF_W-1:0] o_perf_lu,
  output logic [PERF_W-1:0] o_perf_br,
  output logic [PERF_W-1:0] o_perf_mw
);

  localparam int unsigned TMR_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;

  logic             mw;
  logic             abort;
  logic             lu;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  pipe_ctrl_t       ctrl;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs_e       (i_rs1_e),
    .i_rd_m       (i_rd_m),
    .i_rd_w       (i_rd_w),
    .i_regwrite_m (i_regwrite_m),
    .i_regwrite_w (i_regwrite_w),
    .o_fwd        (fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs_e       (i_rs2_e),
    .i_rd_m       (i_rd_m),
    .i_rd_w       (i_rd_w),
    .i_regwrite_m (i_regwrite_m),
    .i_regwrite_w (i_regwrite_w),
    .o_fwd        (fwd_b)
  );

  // Load in E whose destination is read by the instruction in D
  assign lu = i_load_e && (i_rd_e != '0) &&
              ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

  // Dmem wait FSM state, timer and sticky error registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_RUN;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // Dmem wait FSM next-state: wait cycles, completion and timeout abort
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mw      = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_memreq_m && !i_dmem_ready) begin
          state_d = ST_WAIT;
          timer_d = TMR_W'(1);
          mw      = 1'b1;
        end
      end
      ST_WAIT: begin
        if (i_dmem_ready) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_RUN;
          timer_d = '0;
          abort   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          mw      = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    endcase
  end

  // Sticky timeout flag; a new timeout beats a same-cycle clear
  always_comb begin
    err_d = abort | (err_q & ~i_err_clr);
  end

  // Stall/flush priority: reset > mem wait > timeout abort > branch > load-use
  always_comb begin
    ctrl = '0;
    if (!i_rstn) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
      ctrl.flush_m = 1'b1;
    end else if (mw) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.stall_e = 1'b1;
      ctrl.stall_m = 1'b1;
    end else if (abort) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
      ctrl.flush_m = 1'b1;
    end else if (i_pcsrc_e) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (lu) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end
  end

  assign o_stall_f = ctrl.stall_f;
  assign o_stall_d = ctrl.stall_d;
  assign o_stall_e = ctrl.stall_e;
  assign o_stall_m = ctrl.stall_m;
  assign o_flush_d = ctrl.flush_d;
  assign o_flush_e = ctrl.flush_e;
  assign o_flush_m = ctrl.flush_m;
  assign o_fwd_a_e = i_rstn ? fwd_a : FWD_RF;
  assign o_fwd_b_e = i_rstn ? fwd_b : FWD_RF;
  assign o_mem_err = err_q;

`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
  logic [PERF_W-1:0] perf_br_q, perf_br_d;
  logic [PERF_W-1:0] perf_mw_q, perf_mw_d;
  logic              lu_ev;
  logic              br_ev;

  // Events that actually took effect after priority resolution
  assign lu_ev = lu && !i_pcsrc_e && !mw && !abort;
  assign br_ev = i_pcsrc_e && !mw && !abort;

  // Saturating increments
  always_comb begin
    perf_lu_d = perf_lu_q;
    perf_br_d = perf_br_q;
    perf_mw_d = perf_mw_q;
    if (lu_ev && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + PERF_W'(1);
    if (br_ev && (perf_br_q != '1)) perf_br_d = perf_br_q + PERF_W'(1);
    if (mw    && (perf_mw_q != '1)) perf_mw_d = perf_mw_q + PERF_W'(1);
  end

  // Perf counter registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      perf_lu_q <= '0;
      perf_br_q <= '0;
      perf_mw_q <= '0;
    end else begin
      perf_lu_q <= perf_lu_d;
      perf_br_q <= perf_br_d;
      perf_mw_q <= perf_mw_d;
    end
  end

  assign o_perf_lu = perf_lu_q;
  assign o_perf_br = perf_br_q;
  assign o_perf_mw = perf_mw_q;
`else
  assign o_perf_lu = '0;
  assign o_perf_br = '0;
  assign o_perf_mw = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with directed vectors.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned PW = 32;

  typedef struct packed {
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic          load_e, pcsrc_e;
    logic [AW-1:0] rd_m, rd_w;
    logic          rw_m, rw_w, memreq, ready, err_clr, rstn;
  } stim_t;

  typedef struct packed {
    logic [3:0] stall;   // f,d,e,m
    logic [2:0] flush;   // d,e,m
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic          chk;
    logic [PW-1:0] lu, br, mw;
  } perf_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          load_e, pcsrc_e, rw_m, rw_w, memreq, ready, err_clr;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_m, mem_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [PW-1:0] perf_lu, perf_br, perf_mw;

  exp_t  exp_q[$];
  perf_t perf_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    mon_idx  = 0;
  exp_t  mon_e;
  perf_t mon_p;
  logic [12:0] act_ctl, exp_ctl;

  localparam perf_t NOP = '0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(4), .PERF_W(PW)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_rs1_d      (rs1_d),
    .i_rs2_d      (rs2_d),
    .i_rs1_e      (rs1_e),
    .i_rs2_e      (rs2_e),
    .i_rd_e       (rd_e),
    .i_load_e     (load_e),
    .i_pcsrc_e    (pcsrc_e),
    .i_rd_m       (rd_m),
    .i_rd_w       (rd_w),
    .i_regwrite_m (rw_m),
    .i_regwrite_w (rw_w),
    .i_memreq_m   (memreq),
    .i_dmem_ready (ready),
    .i_err_clr    (err_clr),
    .o_stall_f    (stall_f),
    .o_stall_d    (stall_d),
    .o_stall_e    (stall_e),
    .o_stall_m    (stall_m),
    .o_flush_d    (flush_d),
    .o_flush_e    (flush_e),
    .o_flush_m    (flush_m),
    .o_fwd_a_e    (fwd_a),
    .o_fwd_b_e    (fwd_b),
    .o_mem_err    (mem_err),
    .o_perf_lu    (perf_lu),
    .o_perf_br    (perf_br),
    .o_perf_mw    (perf_mw)
  );

  function automatic stim_t idle();
    stim_t s;
    s      = '0;
    s.rstn = 1'b1;
    return s;
  endfunction

  function automatic perf_t pf(input int lu, input int br, input int mw);
    perf_t p;
    p.chk = 1'b1;
    p.lu  = PW'(lu);
    p.br  = PW'(br);
    p.mw  = PW'(mw);
    return p;
  endfunction

  task automatic apply(input stim_t s);
    rs1_d = s.rs1_d;  rs2_d = s.rs2_d;  rs1_e = s.rs1_e;  rs2_e = s.rs2_e;
    rd_e  = s.rd_e;   load_e = s.load_e; pcsrc_e = s.pcsrc_e;
    rd_m  = s.rd_m;   rd_w = s.rd_w;    rw_m = s.rw_m;    rw_w = s.rw_w;
    memreq = s.memreq; ready = s.ready; err_clr = s.err_clr; rstn = s.rstn;
  endtask

  // Drive one cycle of stimulus and queue its expected response
  task automatic step(input stim_t s, input logic [3:0] st, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic err,
                      input perf_t p);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    e.stall = st; e.flush = fl; e.fa = fa; e.fb = fb; e.err = err;
    exp_q.push_back(e);
    perf_q.push_back(p);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_p = perf_q.pop_front();
      act_ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, fwd_a, fwd_b};
      exp_ctl = {mon_e.stall, mon_e.flush, mon_e.fa, mon_e.fb};
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_fail++;
        $display("FAIL ctl step %0d: got stall=%b flush=%b fa=%b fb=%b, want stall=%b flush=%b fa=%b fb=%b",
                 mon_idx, act_ctl[12:9], act_ctl[8:6], act_ctl[5:4], act_ctl[3:0],
                 mon_e.stall, mon_e.flush, mon_e.fa, mon_e.fb);
      end
      n_checks++;
      if (mem_err !== mon_e.err) begin
        n_fail++;
        $display("FAIL mem_err step %0d: got %b want %b", mon_idx, mem_err, mon_e.err);
      end
      if (mon_p.chk) begin
`ifndef HAZ_PERF_EN
        mon_p.lu = '0; mon_p.br = '0; mon_p.mw = '0;
`endif
        n_checks++;
        if ({perf_lu, perf_br, perf_mw} !== {mon_p.lu, mon_p.br, mon_p.mw}) begin
          n_fail++;
          $display("FAIL perf step %0d: got lu=%0d br=%0d mw=%0d want lu=%0d br=%0d mw=%0d",
                   mon_idx, perf_lu, perf_br, perf_mw, mon_p.lu, mon_p.br, mon_p.mw);
        end
      end
      mon_idx++;
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rstn = 1'b0;
    apply(s);

    // Reset: flushes forced, forwarding suppressed
    s = idle(); s.rstn = 1'b0; s.rd_m = 5; s.rw_m = 1; s.rs1_e = 5;
    step(s, 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, pf(0, 0, 0));
    s = idle();
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, NOP);

    // Forwarding
    s = idle(); s.rd_m = 5; s.rw_m = 1; s.rs1_e = 5;
    step(s, 4'b0000, 3'b000, 2'b10, 2'b00, 1'b0, NOP);
    s = idle(); s.rd_w = 5; s.rw_w = 1; s.rs1_e = 5; s.rs2_e = 5;
    step(s, 4'b0000, 3'b000, 2'b01, 2'b01, 1'b0, NOP);
    s = idle(); s.rd_m = 5; s.rw_m = 1; s.rd_w = 5; s.rw_w = 1; s.rs1_e = 5; s.rs2_e = 5;
    step(s, 4'b0000, 3'b000, 2'b10, 2'b10, 1'b0, NOP);
    s = idle(); s.rd_m = 0; s.rw_m = 1; s.rd_w = 0; s.rw_w = 1;
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s = idle(); s.rd_m = 5; s.rw_m = 0; s.rd_w = 5; s.rw_w = 1; s.rs2_e = 5;
    step(s, 4'b0000, 3'b000, 2'b00, 2'b01, 1'b0, NOP);

    // Load-use: lw x6 in E, add x7,x6,x1 in D
    s = idle(); s.load_e = 1; s.rd_e = 6; s.rs1_d = 6; s.rs2_d = 1;
    step(s, 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, NOP);
    s = idle(); s.rs1_d = 6; s.rs2_d = 1; s.rd_m = 6; s.rw_m = 1;
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s = idle(); s.rs1_e = 6; s.rs2_e = 1; s.rd_w = 6; s.rw_w = 1;
    step(s, 4'b0000, 3'b000, 2'b01, 2'b00, 1'b0, NOP);
    s = idle(); s.load_e = 1; s.rd_e = 0; s.rs1_d = 0;
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s = idle(); s.load_e = 1; s.rd_e = 7; s.rs1_d = 3; s.rs2_d = 7;
    step(s, 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, NOP);

    // Branch beats load-use
    s = idle(); s.pcsrc_e = 1; s.load_e = 1; s.rd_e = 6; s.rs1_d = 6;
    step(s, 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, NOP);

    // Three wait cycles, then ready; first wait also has a branch
    s = idle(); s.memreq = 1; s.pcsrc_e = 1;
    step(s, 4'b1111, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s = idle(); s.memreq = 1;
    step(s, 4'b1111, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    step(s, 4'b1111, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s.ready = 1;
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s = idle();
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, pf(2, 1, 3));

    // Timeout with MEM_TIMEOUT=4: three stall cycles, then abort
    s = idle(); s.memreq = 1;
    repeat (3) step(s, 4'b1111, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    step(s, 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, NOP);
    s = idle();
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, NOP);
    s.err_clr = 1;
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, NOP);
    s = idle();
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, NOP);

    // Timeout coinciding with a clear: set wins
    s = idle(); s.memreq = 1;
    repeat (3) step(s, 4'b1111, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s.err_clr = 1;
    step(s, 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, NOP);
    s = idle();
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, pf(2, 1, 9));

    // Reset asserted mid-WAIT
    s = idle(); s.memreq = 1;
    step(s, 4'b1111, 3'b000, 2'b00, 2'b00, 1'b1, NOP);
    step(s, 4'b1111, 3'b000, 2'b00, 2'b00, 1'b1, NOP);
    s.rstn = 0;
    step(s, 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0, pf(0, 0, 0));
    s = idle();
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s = idle(); s.memreq = 1;
    step(s, 4'b1111, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s.ready = 1;
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, NOP);
    s = idle();
    step(s, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, pf(0, 0, 1));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RV32I pipeline (F/D/E/M/W).
- Generates stall, flush and forwarding controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sequences data-memory wait states through a small FSM with a timeout.
- Sits beside the datapath; every output drives pipeline-register enable/clear inputs or the E-stage operand muxes.

Parameters:
- REG_AW, 5, register-index width.
- MEM_TIMEOUT, 16, max consecutive dmem wait cycles before abort (≥2).
- PERF_W, 32, perf counter width (used only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_rs1_d, i_rs2_d  in  REG_AW  source indices in D.
- i_rs1_e, i_rs2_e, i_rd_e  in  REG_AW  indices in E.
- i_load_e  in  1  E instruction is a load (ResultSrc selects memory).
- i_pcsrc_e  in  1  taken branch or jump resolved in E.
- i_rd_m, i_rd_w  in  REG_AW  destination indices in M and W.
- i_regwrite_m, i_regwrite_w  in  1  writeback enables.
- i_memreq_m  in  1  M stage issues a dmem access.
- i_dmem_ready  in  1  dmem completes the access this cycle.
- i_err_clr  in  1  clears the sticky error.
- o_stall_f, o_stall_d, o_stall_e, o_stall_m  out  1  hold the stage register.
- o_flush_d, o_flush_e, o_flush_m  out  1  synchronous bubble insert (clear on next edge).
- o_fwd_a_e, o_fwd_b_e  out  2  operand select: 00 = RF, 01 = W result, 10 = M ALU result.
- o_mem_err  out  1  sticky dmem timeout flag.
- o_perf_lu, o_perf_br, o_perf_mw  out  PERF_W  perf counters.

Behaviour:
- Forwarding (combinational), per operand:
  - 10 if regwrite_m, rd_m≠0 and rd_m==rs_e.
  - Otherwise 01 if regwrite_w, rd_w≠0 and rd_w==rs_e.
  - Otherwise 00.
  - M has priority over W.
- Load-use: lu = i_load_e & rd_e≠0 & (rd_e==rs1_d | rd_e==rs2_d). When set: stall_f = stall_d = 1, flush_e = 1.
- Branch: i_pcsrc_e → flush_d = flush_e = 1.
- Branch and load-use in the same cycle: branch wins. No F/D stall, since the D instruction is wrong-path.
- Memory wait: mw = (state==RUN & memreq_m & !ready) | (state==WAIT & !ready).
  - While mw: stall_f/d/e/m = 1 and all flushes = 0. This overrides branch and load-use.
  - The W register is not stalled; the datapath inserts a W bubble.
- FSM states: RUN, WAIT.
  - RUN→WAIT: memreq_m & !ready. Timer loads 1.
  - WAIT→RUN: ready. Timer clears. Pipeline resumes the next cycle.
  - WAIT, !ready, timer==MEM_TIMEOUT-1 → RUN:
    - mw = 0 and flush_m = flush_e = flush_d = 1 for that cycle.
    - o_mem_err set on the edge.
  - Otherwise in WAIT, timer increments.
- o_mem_err: sticky until i_err_clr, which is synchronous. A set and clear in the same cycle resolves to set.
- Reset (async, i_rstn low):
  - state = RUN, timer = 0, o_mem_err = 0, perf counters = 0.
  - While in reset: flush_d/e/m forced 1, all stalls 0, fwd = 00.
  - A reset asserted mid-WAIT abandons the access with no error.
- No registered latency on stall, flush or fwd. All are combinational from the inputs and state.

Optional Feature:
- Macro: HAZ_PERF_EN.
- Defined:
  - o_perf_lu counts cycles with lu active and not overridden.
  - o_perf_br counts branch flushes.
  - o_perf_mw counts mw cycles.
  - All counters are PERF_W wide and saturate at the all-ones value.
- Undefined: perf ports are tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg: FWD_RF/FWD_WB/FWD_MEM encodings; FSM state enum (ST_RUN, ST_WAIT); REG_AW default.
- One sub-module, hazard_fwd_sel: combinational per-operand forward select, instantiated for operand A and operand B.

Test Plan:
- add x5 in M, then add using x5 in E (rd_m=5, rs1_e=5, regwrite_m=1) → fwd_a_e=10. The same with rd_w=5 only → 01. With rd_m=0 → 00.
- lw x6 in E followed by add x7,x6,x1 in D → stall_f=stall_d=1 and flush_e=1 for exactly one cycle. The next cycle shows fwd 01 from W.
- pcsrc_e=1 with lu also true → flush_d=flush_e=1, stall_f=stall_d=0.
- memreq_m=1 with ready low for 3 cycles → stall_f/d/e/m high for 3 cycles and flushes 0. Stalls release in the cycle ready=1. o_mem_err stays 0.
- ready held low, MEM_TIMEOUT=4 → stalls for 3 cycles, then flush_d/e/m high for 1 cycle and o_mem_err=1 afterwards. i_err_clr → 0.
- Reset pulse mid-WAIT → state RUN, o_mem_err=0, flushes 1 during reset. With HAZ_PERF_EN: counters reset to 0, and o_perf_mw equals the wait count after recovery.
